// File: rtl/mem_stage_if.sv
// Bundle of the execute-side handshake, data-memory port and write-back packet of mem_stage.
// The slave modport is the stage's view; the master modport is the surrounding pipeline/memory.
interface mem_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  inst_type_i;
  logic [7:0]  inst_opcode;
  logic [63:0] exe_result;
  logic [63:0] store_data;
  logic [4:0]  rd_addr_i;
  logic        rd_wen_i;

  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  logic        wb_valid;
  logic [4:0]  wb_inst_type;
  logic [4:0]  wb_rd_addr;
  logic        wb_wen;
  logic [63:0] wb_data;
  logic        misalign;

  modport slave (
    input  in_valid, inst_type_i, inst_opcode, exe_result, store_data, rd_addr_i, rd_wen_i,
    input  mem_ack, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output wb_valid, wb_inst_type, wb_rd_addr, wb_wen, wb_data, misalign
  );

  modport master (
    output in_valid, inst_type_i, inst_opcode, exe_result, store_data, rd_addr_i, rd_wen_i,
    output mem_ack, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  wb_valid, wb_inst_type, wb_rd_addr, wb_wen, wb_data, misalign
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: single-outstanding load/store on the data port, load
// alignment and extension, and a registered one-cycle write-back packet.
module mem_stage (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);

  localparam logic [7:0] INST_LB  = 8'h10;
  localparam logic [7:0] INST_LH  = 8'h11;
  localparam logic [7:0] INST_LW  = 8'h12;
  localparam logic [7:0] INST_LD  = 8'h13;
  localparam logic [7:0] INST_LBU = 8'h14;
  localparam logic [7:0] INST_LHU = 8'h15;
  localparam logic [7:0] INST_LWU = 8'h16;
  localparam logic [7:0] INST_SB  = 8'h18;
  localparam logic [7:0] INST_SH  = 8'h19;
  localparam logic [7:0] INST_SW  = 8'h1A;
  localparam logic [7:0] INST_SD  = 8'h1B;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [2:0]  lane_q, lane_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        rd_wen_q, rd_wen_d;
  logic [4:0]  inst_type_q, inst_type_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  mem_wmask_q, mem_wmask_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_inst_type_q, wb_inst_type_d;
  logic [4:0]  wb_rd_addr_q, wb_rd_addr_d;
  logic        wb_wen_q, wb_wen_d;
  logic [63:0] wb_data_q, wb_data_d;
  logic        misalign_q, misalign_d;

  logic        in_load, in_store, in_misal, fire;
  logic [1:0]  in_size;
  logic [2:0]  in_lane;
  logic [7:0]  st_mask;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic [63:0] ld_shift, ld_data;

  assign in_lane = bus.exe_result[2:0];
  assign fire    = bus.in_valid && (state_q == StIdle);

  // Incoming opcode: class and access size (0=B, 1=H, 2=W, 3=D).
  always_comb begin
    in_load  = 1'b0;
    in_store = 1'b0;
    in_size  = 2'd0;
    case (bus.inst_opcode)
      INST_LB, INST_LBU: begin in_load = 1'b1;  in_size = 2'd0; end
      INST_LH, INST_LHU: begin in_load = 1'b1;  in_size = 2'd1; end
      INST_LW, INST_LWU: begin in_load = 1'b1;  in_size = 2'd2; end
      INST_LD:           begin in_load = 1'b1;  in_size = 2'd3; end
      INST_SB:           begin in_store = 1'b1; in_size = 2'd0; end
      INST_SH:           begin in_store = 1'b1; in_size = 2'd1; end
      INST_SW:           begin in_store = 1'b1; in_size = 2'd2; end
      INST_SD:           begin in_store = 1'b1; in_size = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    in_misal = 1'b0;
    st_mask  = 8'hFF;
    case (in_size)
      2'd0: begin in_misal = 1'b0;            st_mask = 8'h01 << in_lane; end
      2'd1: begin in_misal = in_lane[0];      st_mask = 8'h03 << in_lane; end
      2'd2: begin in_misal = |in_lane[1:0];   st_mask = 8'h0F << in_lane; end
      default: begin in_misal = |in_lane;     st_mask = 8'hFF; end
    endcase
  end

  // Captured load opcode drives extraction of the returning doubleword.
  always_comb begin
    ld_size     = 2'd3;
    ld_unsigned = 1'b0;
    case (op_q)
      INST_LB:  ld_size = 2'd0;
      INST_LH:  ld_size = 2'd1;
      INST_LW:  ld_size = 2'd2;
      INST_LBU: begin ld_size = 2'd0; ld_unsigned = 1'b1; end
      INST_LHU: begin ld_size = 2'd1; ld_unsigned = 1'b1; end
      INST_LWU: begin ld_size = 2'd2; ld_unsigned = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    ld_shift = bus.mem_rdata >> {lane_q, 3'b000};
    case (ld_size)
      2'd0:    ld_data = ld_unsigned ? {56'd0, ld_shift[7:0]}
                                     : {{56{ld_shift[7]}}, ld_shift[7:0]};
      2'd1:    ld_data = ld_unsigned ? {48'd0, ld_shift[15:0]}
                                     : {{48{ld_shift[15]}}, ld_shift[15:0]};
      2'd2:    ld_data = ld_unsigned ? {32'd0, ld_shift[31:0]}
                                     : {{32{ld_shift[31]}}, ld_shift[31:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    lane_d         = lane_q;
    rd_addr_d      = rd_addr_q;
    rd_wen_d       = rd_wen_q;
    inst_type_d    = inst_type_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_wmask_d    = mem_wmask_q;
    wb_valid_d     = 1'b0;
    wb_inst_type_d = wb_inst_type_q;
    wb_rd_addr_d   = wb_rd_addr_q;
    wb_wen_d       = wb_wen_q;
    wb_data_d      = wb_data_q;
    misalign_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (fire) begin
          if (!in_load && !in_store) begin
            wb_valid_d     = 1'b1;
            wb_inst_type_d = bus.inst_type_i;
            wb_rd_addr_d   = bus.rd_addr_i;
            wb_wen_d       = bus.rd_wen_i && (bus.rd_addr_i != 5'd0);
            wb_data_d      = bus.exe_result;
          end else if (in_misal) begin
            wb_valid_d     = 1'b1;
            misalign_d     = 1'b1;
            wb_inst_type_d = bus.inst_type_i;
            wb_rd_addr_d   = bus.rd_addr_i;
            wb_wen_d       = 1'b0;
            wb_data_d      = 64'd0;
          end else begin
            state_d     = StBusy;
            op_d        = bus.inst_opcode;
            lane_d      = in_lane;
            rd_addr_d   = bus.rd_addr_i;
            rd_wen_d    = bus.rd_wen_i;
            inst_type_d = bus.inst_type_i;
            mem_req_d   = 1'b1;
            mem_we_d    = in_store;
            mem_addr_d  = {bus.exe_result[63:3], 3'b000};
            mem_wdata_d = in_store ? (bus.store_data << {in_lane, 3'b000}) : 64'd0;
            mem_wmask_d = in_store ? st_mask : 8'h00;
          end
        end
      end
      StBusy: begin
        if (bus.mem_ack) begin
          state_d        = StResp;
          mem_req_d      = 1'b0;
          wb_valid_d     = 1'b1;
          wb_inst_type_d = inst_type_q;
          wb_rd_addr_d   = rd_addr_q;
          wb_wen_d       = !mem_we_q && rd_wen_q && (rd_addr_q != 5'd0);
          wb_data_d      = mem_we_q ? 64'd0 : ld_data;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      op_q           <= 8'd0;
      lane_q         <= 3'd0;
      rd_addr_q      <= 5'd0;
      rd_wen_q       <= 1'b0;
      inst_type_q    <= 5'd0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 64'd0;
      mem_wdata_q    <= 64'd0;
      mem_wmask_q    <= 8'd0;
      wb_valid_q     <= 1'b0;
      wb_inst_type_q <= 5'd0;
      wb_rd_addr_q   <= 5'd0;
      wb_wen_q       <= 1'b0;
      wb_data_q      <= 64'd0;
      misalign_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      lane_q         <= lane_d;
      rd_addr_q      <= rd_addr_d;
      rd_wen_q       <= rd_wen_d;
      inst_type_q    <= inst_type_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_wmask_q    <= mem_wmask_d;
      wb_valid_q     <= wb_valid_d;
      wb_inst_type_q <= wb_inst_type_d;
      wb_rd_addr_q   <= wb_rd_addr_d;
      wb_wen_q       <= wb_wen_d;
      wb_data_q      <= wb_data_d;
      misalign_q     <= misalign_d;
    end
  end

  assign bus.in_ready     = (state_q == StIdle);
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_wmask    = mem_wmask_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_inst_type = wb_inst_type_q;
  assign bus.wb_rd_addr   = wb_rd_addr_q;
  assign bus.wb_wen       = wb_wen_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.misalign     = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected write-back packets into a queue,
// a negedge monitor pops and compares each one the stage retires.
module tb_mem_stage;

  localparam logic [7:0] OpAdd = 8'h01;
  localparam logic [7:0] OpLb  = 8'h10;
  localparam logic [7:0] OpLw  = 8'h12;
  localparam logic [7:0] OpLd  = 8'h13;
  localparam logic [7:0] OpLbu = 8'h14;
  localparam logic [7:0] OpSb  = 8'h18;
  localparam logic [7:0] OpSh  = 8'h19;

  typedef struct packed {
    logic [4:0]  itype;
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] data;
    logic        mis;
  } wb_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  wb_t  exp_q[$];

  mem_stage_if bus();

  mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] it, input logic [4:0] rd, input logic wen,
                      input logic [63:0] data, input logic mis);
    wb_t e;
    e = '{itype: it, rd: rd, wen: wen, data: data, mis: mis};
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    wb_t got;
    wb_t exp;
    if (bus.wb_valid === 1'b1) begin
      got = '{itype: bus.wb_inst_type, rd: bus.wb_rd_addr, wen: bus.wb_wen,
              data: bus.wb_data, mis: bus.misalign};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wb_unexpected: got %h expected no write-back", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_err++;
          $display("FAIL wb_packet: got %h expected %h", got, exp);
        end
      end
    end
  end

  task automatic issue(input logic [4:0] it, input logic [7:0] op, input logic [63:0] res,
                       input logic [63:0] sd, input logic [4:0] rd, input logic wen);
    int k;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 64) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 64) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: got in_ready=%b expected 1", bus.in_ready);
    end
    bus.in_valid    = 1'b1;
    bus.inst_type_i = it;
    bus.inst_opcode = op;
    bus.exe_result  = res;
    bus.store_data  = sd;
    bus.rd_addr_i   = rd;
    bus.rd_wen_i    = wen;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Plays the memory side: checks the held request, acks after `waits` extra cycles.
  task automatic mem_access(input string name, input logic [63:0] exp_addr, input int waits,
                            input logic [63:0] rdata, input logic exp_we,
                            input logic [7:0] exp_mask, input logic [63:0] exp_wdata);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      chk({name, "_req"}, 64'(bus.mem_req), 64'd1);
      chk({name, "_addr"}, bus.mem_addr, exp_addr);
      chk({name, "_busy_ready"}, 64'(bus.in_ready), 64'd0);
      if (i == 0) begin
        chk({name, "_we"}, 64'(bus.mem_we), 64'(exp_we));
        chk({name, "_wmask"}, 64'(bus.mem_wmask), 64'(exp_mask));
        if (exp_we) chk({name, "_wdata"}, bus.mem_wdata, exp_wdata);
      end
      if (i == waits) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
      end
    end
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk({name, "_req_drop"}, 64'(bus.mem_req), 64'd0);
    chk({name, "_resp_ready"}, 64'(bus.in_ready), 64'd0);
    chk({name, "_wb_valid"}, 64'(bus.wb_valid), 64'd1);
    @(negedge clk);
    chk({name, "_ready_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int k;
    bus.in_valid    = 1'b0;
    bus.inst_type_i = '0;
    bus.inst_opcode = '0;
    bus.exe_result  = '0;
    bus.store_data  = '0;
    bus.rd_addr_i   = '0;
    bus.rd_wen_i    = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_wb_wen", 64'(bus.wb_wen), 64'd0);
    chk("rst_misalign", 64'(bus.misalign), 64'd0);
    chk("rst_wb_data", bus.wb_data, 64'd0);
    chk("rst_mem_addr", bus.mem_addr, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Back-to-back ALU ops, one retire per cycle.
    push(5'd1, 5'd3, 1'b1, 64'h5, 1'b0);
    issue(5'd1, OpAdd, 64'h5, 64'h0, 5'd3, 1'b1);
    @(negedge clk);
    chk("add1_wb_valid", 64'(bus.wb_valid), 64'd1);
    push(5'd1, 5'd4, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0);
    issue(5'd1, OpAdd, 64'h1234_5678_9ABC_DEF0, 64'h0, 5'd4, 1'b1);
    @(negedge clk);
    chk("add2_wb_valid", 64'(bus.wb_valid), 64'd1);

    // Loads with sign/zero extension, two wait cycles.
    push(5'd2, 5'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    issue(5'd2, OpLb, 64'h1003, 64'h0, 5'd5, 1'b1);
    mem_access("lb", 64'h1000, 2, 64'h0000_0000_8000_0000, 1'b0, 8'h00, 64'h0);
    push(5'd2, 5'd6, 1'b1, 64'h80, 1'b0);
    issue(5'd2, OpLbu, 64'h1003, 64'h0, 5'd6, 1'b1);
    mem_access("lbu", 64'h1000, 2, 64'h0000_0000_8000_0000, 1'b0, 8'h00, 64'h0);

    // Stores never write the register file.
    push(5'd3, 5'd7, 1'b0, 64'h0, 1'b0);
    issue(5'd3, OpSh, 64'h2006, 64'hABCD, 5'd7, 1'b1);
    mem_access("sh", 64'h2000, 0, 64'h0, 1'b1, 8'hC0, 64'hABCD_0000_0000_0000);
    push(5'd3, 5'd0, 1'b0, 64'h0, 1'b0);
    issue(5'd3, OpSb, 64'h6005, 64'h1122_3344_5566_77AB, 5'd0, 1'b0);
    mem_access("sb", 64'h6000, 0, 64'h0, 1'b1, 8'h20, 64'h6677_AB00_0000_0000);

    push(5'd2, 5'd8, 1'b1, 64'hFFFF_FFFF_8000_0001, 1'b0);
    issue(5'd2, OpLw, 64'h5004, 64'h0, 5'd8, 1'b1);
    mem_access("lw", 64'h5000, 1, 64'h8000_0001_1234_5678, 1'b0, 8'h00, 64'h0);

    // Misaligned word load: no request, immediate flagged retire.
    push(5'd2, 5'd9, 1'b0, 64'h0, 1'b1);
    issue(5'd2, OpLw, 64'h3002, 64'h0, 5'd9, 1'b1);
    @(negedge clk);
    chk("misal_no_req", 64'(bus.mem_req), 64'd0);
    chk("misal_flag", 64'(bus.misalign), 64'd1);
    @(negedge clk);
    chk("misal_no_req2", 64'(bus.mem_req), 64'd0);
    chk("misal_ready", 64'(bus.in_ready), 64'd1);

    // rd=x0 suppresses the write enable.
    push(5'd1, 5'd0, 1'b0, 64'h42, 1'b0);
    issue(5'd1, OpAdd, 64'h42, 64'h0, 5'd0, 1'b1);
    @(negedge clk);
    chk("x0_wb_valid", 64'(bus.wb_valid), 64'd1);

    // Reset while a load is in flight abandons it.
    issue(5'd2, OpLd, 64'h4000, 64'h0, 5'd10, 1'b1);
    @(negedge clk);
    chk("ld_req", 64'(bus.mem_req), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ld_rst_req_drop", 64'(bus.mem_req), 64'd0);
    chk("ld_rst_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("ld_rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    @(posedge clk);
    #1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_req", 64'(bus.mem_req), 64'd0);
    chk("stray_ack_wb", 64'(bus.wb_valid), 64'd0);
    chk("stray_ack_ready", 64'(bus.in_ready), 64'd1);

    push(5'd1, 5'd11, 1'b1, 64'h77, 1'b0);
    issue(5'd1, OpAdd, 64'h77, 64'h0, 5'd11, 1'b1);
    @(negedge clk);
    chk("post_rst_wb_valid", 64'(bus.wb_valid), 64'd1);

    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
